// File: rtl/svk_ahb_arbiter.sv
// svk_ahb_arbiter
//   Bus arbiter for the multi-master AHB fabric. Shares one address/data path
//   among NUM_MASTER requesters through hbusreq/hgrant and publishes the
//   address-phase owner (hmaster) and lock status (hmastlock) for the fabric
//   muxes. Grants only move at burst boundaries: after the last address beat
//   of a fixed-length burst, on any beat of an undefined-length INCR, on
//   IDLE, and never while the granted master holds hlock.
//
// Parameters
//   NUM_MASTER      number of requesters (2 or more)
//   DEFAULT_MASTER  master granted when nobody requests; also the reset owner
//   ARB_MODE        0 = fixed priority (index 0 highest), 1 = round robin
//   MW              width of a master index (derived)
//
// Ports
//   hclk       in   AHB clock, all state on the rising edge
//   hresetn    in   asynchronous active-low reset
//   hbusreq    in   per-master bus request
//   hlock      in   per-master locked-transfer request
//   htrans     in   HTRANS of the muxed current address-phase owner
//   hburst     in   HBURST of the muxed current address-phase owner
//   hready     in   shared HREADY from the slave side
//   hgrant     out  one-hot grant (registered)
//   hmaster    out  index of the master owning the current address phase
//   hmastlock  out  current address phase belongs to a locked sequence

module svk_ahb_arbiter #(
  parameter int NUM_MASTER     = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 1,
  localparam int MW            = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [NUM_MASTER-1:0] hbusreq,
  input  logic [NUM_MASTER-1:0] hlock,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [NUM_MASTER-1:0] hgrant,
  output logic [MW-1:0]         hmaster,
  output logic                  hmastlock
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [MW-1:0]         DEFAULT_IDX   = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTER-1:0] DEFAULT_GRANT =
    {{(NUM_MASTER-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  // Number of address beats in a burst; 0 marks undefined-length INCR.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    logic [4:0] len;
    case (burst)
      3'b000:          len = 5'd1;
      3'b001:          len = 5'd0;
      3'b010, 3'b011:  len = 5'd4;
      3'b100, 3'b101:  len = 5'd8;
      default:         len = 5'd16;
    endcase
    return len;
  endfunction

  logic [NUM_MASTER-1:0] hgrant_q;
  logic [NUM_MASTER-1:0] grant_d;
  logic [MW-1:0]         grant_idx;
  logic [MW-1:0]         winner;
  logic [MW-1:0]         rr_ptr_q;
  logic [MW-1:0]         rr_ptr_d;
  logic [3:0]            cnt_q;
  logic [3:0]            cnt_d;
  logic [4:0]            cur_len;
  logic                  any_req;
  logic                  arb_point;
  logic                  arb_ok;
  htrans_e               trans;

  assign trans   = htrans_e'(htrans);
  assign cur_len = burst_len(hburst);
  assign any_req = |hbusreq;
  assign hgrant  = hgrant_q;

  // Index of the currently granted master (hgrant is always one-hot).
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (hgrant_q[i]) grant_idx = MW'(i);
    end
  end

  // Beats still expected after the current one. cnt==1 on a SEQ means this
  // is the final address beat of a fixed burst; cnt==0 means no fixed burst
  // is in flight (INCR, SINGLE, or idle).
  always_comb begin
    cnt_d = cnt_q;
    case (trans)
      TRANS_NONSEQ: cnt_d = (cur_len == 5'd0) ? 4'd0 : 4'(cur_len - 5'd1);
      TRANS_SEQ:    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      TRANS_IDLE:   cnt_d = 4'd0;
      default:      cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    arb_point = 1'b0;
    case (trans)
      TRANS_IDLE:   arb_point = 1'b1;
      TRANS_NONSEQ: arb_point = (cur_len <= 5'd1);
      TRANS_SEQ:    arb_point = (cnt_q <= 4'd1);
      default:      arb_point = 1'b0;
    endcase
  end

  // A locked owner keeps the bus regardless of burst position.
  assign arb_ok = hready & arb_point & ~hlock[grant_idx];

  always_comb begin
    int  cand;
    logic found;
    cand   = 0;
    found  = 1'b0;
    winner = DEFAULT_IDX;
    if (ARB_MODE == 0) begin
      for (int i = NUM_MASTER - 1; i >= 0; i--) begin
        if (hbusreq[i]) winner = MW'(i);
      end
    end else begin
      // Search starts just after the last winner and wraps, so the last
      // winner is considered last.
      for (int k = 1; k <= NUM_MASTER; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_MASTER) cand = cand - NUM_MASTER;
        if (!found && hbusreq[cand]) begin
          winner = MW'(cand);
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_d = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      grant_d[i] = (winner == MW'(i));
    end
  end

  // The pointer only follows real request winners; a fallback to the
  // default master with nobody asking leaves the rotation where it was.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_req) rr_ptr_d = winner;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hgrant_q  <= DEFAULT_GRANT;
      hmaster   <= DEFAULT_IDX;
      hmastlock <= 1'b0;
      cnt_q     <= 4'd0;
      rr_ptr_q  <= DEFAULT_IDX;
    end else if (hready) begin
      cnt_q     <= cnt_d;
      // hmaster trails hgrant by one accepted cycle so it lines up with the
      // address phase the newly granted master drives.
      hmaster   <= grant_idx;
      hmastlock <= hlock[grant_idx];
      if (arb_ok) begin
        hgrant_q <= grant_d;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

endmodule

// File: tb/tb_svk_ahb_arbiter.sv
module tb_svk_ahb_arbiter;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_WRAP16 = 3'b110;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;

  logic [3:0] hgrant_fp, hgrant_rr;
  logic [1:0] hmaster_fp, hmaster_rr;
  logic       hmastlock_fp, hmastlock_rr;

  int n_checks = 0;
  int n_fail   = 0;

  svk_ahb_arbiter #(.NUM_MASTER(4), .DEFAULT_MASTER(0), .ARB_MODE(0)) u_dut_fp (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant_fp), .hmaster(hmaster_fp), .hmastlock(hmastlock_fp)
  );

  svk_ahb_arbiter #(.NUM_MASTER(4), .DEFAULT_MASTER(0), .ARB_MODE(1)) u_dut_rr (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant_rr), .hmaster(hmaster_rr), .hmastlock(hmastlock_rr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] g_fp, input logic [3:0] g_rr,
                          input logic [1:0] m_fp, input logic [1:0] m_rr);
    chk({tag, "_grant_fp"}, hgrant_fp, g_fp);
    chk({tag, "_grant_rr"}, hgrant_rr, g_rr);
    chk({tag, "_hmaster_fp"}, hmaster_fp, m_fp);
    chk({tag, "_hmaster_rr"}, hmaster_rr, m_rr);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy);
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    step();
  endtask

  task automatic do_reset();
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = T_IDLE;
    hburst  = B_SINGLE;
    hready  = 1'b1;
    hresetn = 1'b0;
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  // ---------------- reference model (index 0: fixed priority, 1: round robin)
  int m_owner[2];
  int m_hmaster[2];
  int m_rr[2];
  int m_blen[2];
  int m_beat[2];
  bit m_mlock[2];

  function automatic int blen(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m]   = 0;
      m_hmaster[m] = 0;
      m_rr[m]      = 0;
      m_blen[m]    = 0;
      m_beat[m]    = 0;
      m_mlock[m]   = 1'b0;
    end
  endtask

  // Burst tracked as (declared length, beats issued so far); a SEQ beat is a
  // handover point once it is the last declared beat or the burst has no
  // declared length.
  task automatic model_edge();
    int old;
    int c;
    bit point;
    if (hready !== 1'b1) return;
    for (int m = 0; m < 2; m++) begin
      old = m_owner[m];
      case (htrans)
        T_IDLE:   point = 1'b1;
        T_BUSY:   point = 1'b0;
        T_NONSEQ: point = (blen(hburst) <= 1);
        default:  point = (m_blen[m] == 0) || (m_beat[m] + 1 >= m_blen[m]);
      endcase
      case (htrans)
        T_IDLE:   begin m_blen[m] = 0; m_beat[m] = 0; end
        T_NONSEQ: begin m_blen[m] = blen(hburst); m_beat[m] = 1; end
        T_SEQ:    m_beat[m] = m_beat[m] + 1;
        default:  ;
      endcase
      m_hmaster[m] = old;
      m_mlock[m]   = hlock[old];
      if (point && !hlock[old]) begin
        if (hbusreq == 4'b0000) begin
          m_owner[m] = 0;
        end else if (m == 0) begin
          for (int k = 3; k >= 0; k--) if (hbusreq[k]) m_owner[m] = k;
        end else begin
          for (int k = 1; k <= 4; k++) begin
            c = (m_rr[m] + k) % 4;
            if (hbusreq[c]) begin
              m_owner[m] = c;
              m_rr[m]    = c;
              break;
            end
          end
        end
      end
    end
  endtask

  // ---------------- directed vector table
  typedef struct packed {
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] fp_g;
    logic [1:0] fp_m;
    logic [3:0] rr_g;
    logic [1:0] rr_m;
    logic       ml;
  } vec_t;

  localparam int NVEC = 19;
  vec_t tbl[NVEC];

  initial begin
    // INCR4 owned by M2 with M1 joining, then a locked M3 sequence, then
    // all four requesting SINGLEs.
    tbl[0]  = '{4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd0, 4'b0100, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[2]  = '{4'b0100, 4'b0000, T_NONSEQ, B_INCR4,  1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[3]  = '{4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[4]  = '{4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b0100, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[5]  = '{4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b0, 4'b0100, 2'd2, 4'b0100, 2'd2, 1'b0};
    tbl[6]  = '{4'b0110, 4'b0000, T_SEQ,    B_INCR4,  1'b1, 4'b0010, 2'd2, 4'b0010, 2'd2, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0010, 2'd1, 4'b0010, 2'd1, 1'b0};
    tbl[8]  = '{4'b1000, 4'b1000, T_IDLE,   B_SINGLE, 1'b1, 4'b1000, 2'd1, 4'b1000, 2'd1, 1'b0};
    tbl[9]  = '{4'b1001, 4'b1000, T_IDLE,   B_SINGLE, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3, 1'b1};
    tbl[10] = '{4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3, 1'b1};
    tbl[11] = '{4'b1001, 4'b1000, T_NONSEQ, B_SINGLE, 1'b1, 4'b1000, 2'd3, 4'b1000, 2'd3, 1'b1};
    tbl[12] = '{4'b0001, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd3, 4'b0001, 2'd3, 1'b0};
    tbl[13] = '{4'b0000, 4'b0000, T_IDLE,   B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd0, 1'b0};
    tbl[14] = '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b0010, 2'd0, 1'b0};
    tbl[15] = '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b0100, 2'd1, 1'b0};
    tbl[16] = '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b1000, 2'd2, 1'b0};
    tbl[17] = '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b0001, 2'd3, 1'b0};
    tbl[18] = '{4'b1111, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1, 4'b0001, 2'd0, 4'b0010, 2'd0, 1'b0};
  end

  initial begin
    // Reset held with every master requesting.
    hresetn = 1'b0;
    hbusreq = 4'b1111;
    hlock   = 4'b0000;
    htrans  = T_IDLE;
    hburst  = B_SINGLE;
    hready  = 1'b1;
    step();
    step();
    chk_both("reset", 4'b0001, 4'b0001, 2'd0, 2'd0);
    chk("reset_mlock_fp", hmastlock_fp, 1'b0);
    chk("reset_mlock_rr", hmastlock_rr, 1'b0);
    @(negedge hclk);
    hresetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].burst, tbl[i].rdy);
      chk_both($sformatf("tbl%0d", i), tbl[i].fp_g, tbl[i].rr_g, tbl[i].fp_m, tbl[i].rr_m);
      chk($sformatf("tbl%0d_mlock_fp", i), hmastlock_fp, tbl[i].ml);
      chk($sformatf("tbl%0d_mlock_rr", i), hmastlock_rr, tbl[i].ml);
    end

    // INCR8 from M0 with three wait states mid-burst; M1 takes over only
    // after the eighth address beat is accepted.
    do_reset();
    drive(4'b0001, 4'b0000, T_NONSEQ, B_INCR8, 1'b1);
    chk_both("incr8_b1", 4'b0001, 4'b0001, 2'd0, 2'd0);
    for (int b = 2; b <= 4; b++) begin
      drive(4'b0010, 4'b0000, T_SEQ, B_INCR8, 1'b1);
      chk_both($sformatf("incr8_b%0d", b), 4'b0001, 4'b0001, 2'd0, 2'd0);
    end
    for (int w = 0; w < 3; w++) begin
      drive(4'b0010, 4'b0000, T_SEQ, B_INCR8, 1'b0);
      chk_both($sformatf("incr8_wait%0d", w), 4'b0001, 4'b0001, 2'd0, 2'd0);
    end
    for (int b = 5; b <= 7; b++) begin
      drive(4'b0010, 4'b0000, T_SEQ, B_INCR8, 1'b1);
      chk_both($sformatf("incr8_b%0d", b), 4'b0001, 4'b0001, 2'd0, 2'd0);
    end
    drive(4'b0010, 4'b0000, T_SEQ, B_INCR8, 1'b1);
    chk_both("incr8_b8", 4'b0010, 4'b0010, 2'd0, 2'd0);
    drive(4'b0010, 4'b0000, T_NONSEQ, B_SINGLE, 1'b1);
    chk_both("incr8_after", 4'b0010, 4'b0010, 2'd1, 2'd1);

    // Idle default ownership, then reset in the middle of a WRAP16.
    do_reset();
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    drive(4'b0000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    chk_both("idle_default", 4'b0001, 4'b0001, 2'd0, 2'd0);
    drive(4'b0100, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    chk_both("w16_grant", 4'b0100, 4'b0100, 2'd0, 2'd0);
    drive(4'b0100, 4'b0000, T_NONSEQ, B_WRAP16, 1'b1);
    chk_both("w16_b1", 4'b0100, 4'b0100, 2'd2, 2'd2);
    for (int b = 2; b <= 4; b++) begin
      drive(4'b0100, 4'b0000, T_SEQ, B_WRAP16, 1'b1);
      chk_both($sformatf("w16_b%0d", b), 4'b0100, 4'b0100, 2'd2, 2'd2);
    end
    hbusreq = 4'b0100;
    htrans  = T_SEQ;
    #2;
    hresetn = 1'b0;
    #1;
    chk_both("w16_rst", 4'b0001, 4'b0001, 2'd0, 2'd0);
    chk("w16_rst_mlock_fp", hmastlock_fp, 1'b0);
    chk("w16_rst_mlock_rr", hmastlock_rr, 1'b0);
    #2;
    hresetn = 1'b1;
    // A stray SEQ right after reset is a handover point only if the beat
    // counter was cleared.
    drive(4'b0010, 4'b0000, T_SEQ, B_WRAP16, 1'b1);
    chk_both("post_rst_seq", 4'b0010, 4'b0010, 2'd0, 2'd0);
    drive(4'b1000, 4'b0000, T_NONSEQ, B_INCR4, 1'b1);
    chk_both("post_rst_b1", 4'b0010, 4'b0010, 2'd1, 2'd1);
    for (int b = 2; b <= 3; b++) begin
      drive(4'b1000, 4'b0000, T_SEQ, B_INCR4, 1'b1);
      chk_both($sformatf("post_rst_b%0d", b), 4'b0010, 4'b0010, 2'd1, 2'd1);
    end
    drive(4'b1000, 4'b0000, T_SEQ, B_INCR4, 1'b1);
    chk_both("post_rst_b4", 4'b1000, 4'b1000, 2'd1, 2'd1);
    drive(4'b1000, 4'b0000, T_IDLE, B_SINGLE, 1'b1);
    chk_both("post_rst_idle", 4'b1000, 4'b1000, 2'd3, 2'd3);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      hbusreq = 4'($urandom_range(0, 15));
      hlock   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      htrans  = 2'($urandom_range(0, 3));
      hburst  = 3'($urandom_range(0, 7));
      hready  = ($urandom_range(0, 4) != 0);
      @(posedge hclk);
      model_edge();
      #1;
      chk("rnd_grant_fp", hgrant_fp, 32'(1) << m_owner[0]);
      chk("rnd_grant_rr", hgrant_rr, 32'(1) << m_owner[1]);
      chk("rnd_hmaster_fp", hmaster_fp, m_hmaster[0]);
      chk("rnd_hmaster_rr", hmaster_rr, m_hmaster[1]);
      chk("rnd_mlock_fp", hmastlock_fp, m_mlock[0]);
      chk("rnd_mlock_rr", hmastlock_rr, m_mlock[1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
